draw_scheduler: RTL and testbench

Frame-paced controller that owns the single VGA pixel-write port and shares it between up to N drawing clients: player animator, egg animators, score/erase painters. Each frame tick, it snapshots which clients are requesting a slot. It then starts them one at a time in fixed index order using a go/done handshake, and muxes the active client's pixel stream onto the VGA port. It sits between the animate/draw FSMs and the VGA adapter, and replaces ad-hoc OR-ing of writeEn lines.

---
 rtl/draw_scheduler.sv | 218 +++++++++++++++++++++
 tb/tb_draw_scheduler.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/draw_scheduler.sv
// draw_scheduler: frame-paced arbiter for the single VGA pixel-write port.
// Each frame tick it snapshots the client request mask, then starts clients
// one at a time (lowest index first) with a go/done handshake, forwarding the
// active client's pixel stream to the VGA port while that client is busy.
module draw_scheduler #(
   parameter int N_CLIENTS   = 4,
   parameter int FRAME_TICKS = 833333,
   parameter int MAX_BUSY    = 65535
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic                     enable,
   input  logic [N_CLIENTS-1:0]     req,
   input  logic [N_CLIENTS-1:0]     done,
   input  logic [8*N_CLIENTS-1:0]   pix_x,
   input  logic [7*N_CLIENTS-1:0]   pix_y,
   input  logic [3*N_CLIENTS-1:0]   pix_colour,
   input  logic [N_CLIENTS-1:0]     pix_we,
   output logic [N_CLIENTS-1:0]     go,
   output logic [7:0]               vga_x,
   output logic [6:0]               vga_y,
   output logic [2:0]               vga_colour,
   output logic                     vga_we,
   output logic                     frame_start,
   output logic                     pass_done,
   output logic                     timeout,
   output logic                     overrun
);

   localparam int GW = $clog2(N_CLIENTS);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SCAN = 2'd1,
      GO   = 2'd2,
      BUSY = 2'd3
   } state_t;

   state_t               state;
   state_t               state_next;
   logic [19:0]          frame_cnt;
   logic                 tick;
   logic                 tick_pending;
   logic                 consume;
   logic [N_CLIENTS-1:0] mask;
   logic [N_CLIENTS-1:0] mask_next;
   logic [GW-1:0]        grant;
   logic [GW-1:0]        grant_next;
   logic [GW-1:0]        low_idx;
   logic [N_CLIENTS-1:0] low_onehot;
   logic [15:0]          busy_cnt;
   logic [15:0]          busy_cnt_next;
   logic                 done_sel;
   logic                 go_set;
   logic                 fs_set;
   logic                 pd_set;
   logic                 to_set;

   // A frame tick fires on the last count of the frame, only while running.
   assign tick = enable && (frame_cnt == 20'(FRAME_TICKS - 1));

   // Frame counter: counts while enabled, wraps on tick, holds otherwise.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         frame_cnt <= 20'd0;
      end else if (enable) begin
         frame_cnt <= tick ? 20'd0 : frame_cnt + 20'd1;
      end
   end

   // Pending-frame flag and overrun detection (a tick lost on an already pending flag).
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         tick_pending <= 1'b0;
         overrun      <= 1'b0;
      end else begin
         tick_pending <= (tick_pending && !consume) || tick;
         overrun      <= tick && tick_pending && !consume;
      end
   end

   // Lowest set bit of the remaining mask (the next client to be served).
   always_comb begin
      low_idx    = '0;
      low_onehot = '0;
      for (int i = N_CLIENTS - 1; i >= 0; i--) begin
         if (mask[i]) begin
            low_idx    = GW'(i);
            low_onehot = '0;
            low_onehot[i] = 1'b1;
         end else begin
            low_idx    = low_idx;
            low_onehot = low_onehot;
         end
      end
   end

   // Completion from the granted client only; everyone else's done is ignored.
   always_comb begin
      done_sel = 1'b0;
      for (int i = 0; i < N_CLIENTS; i++) begin
         if (grant == GW'(i)) begin
            done_sel = done[i];
         end else begin
            done_sel = done_sel;
         end
      end
   end

   // Next-state logic for the pass sequencer and the one-cycle pulse requests.
   always_comb begin
      state_next    = state;
      mask_next     = mask;
      grant_next    = grant;
      busy_cnt_next = busy_cnt;
      consume       = 1'b0;
      go_set        = 1'b0;
      fs_set        = 1'b0;
      pd_set        = 1'b0;
      to_set        = 1'b0;
      case (state)
         IDLE: begin
            if (tick_pending) begin
               consume    = 1'b1;
               mask_next  = req;
               fs_set     = 1'b1;
               state_next = SCAN;
            end else begin
               state_next = IDLE;
            end
         end
         SCAN: begin
            if (mask == '0) begin
               pd_set     = 1'b1;
               state_next = IDLE;
            end else begin
               grant_next = low_idx;
               mask_next  = mask & ~low_onehot;
               go_set     = 1'b1;
               state_next = GO;
            end
         end
         GO: begin
            busy_cnt_next = 16'd0;
            state_next    = BUSY;
         end
         BUSY: begin
            if (done_sel) begin
               state_next = SCAN;
            end else if (busy_cnt == 16'(MAX_BUSY - 1)) begin
               to_set     = 1'b1;
               state_next = SCAN;
            end else begin
               busy_cnt_next = busy_cnt + 16'd1;
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // Sequencer state, snapshot mask, grant and watchdog counter.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state    <= IDLE;
         mask     <= '0;
         grant    <= '0;
         busy_cnt <= 16'd0;
      end else begin
         state    <= state_next;
         mask     <= mask_next;
         grant    <= grant_next;
         busy_cnt <= busy_cnt_next;
      end
   end

   // Registered one-cycle pulses; go is high during the GO state only.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         go          <= '0;
         frame_start <= 1'b0;
         pass_done   <= 1'b0;
         timeout     <= 1'b0;
      end else begin
         go          <= go_set ? low_onehot : '0;
         frame_start <= fs_set;
         pass_done   <= pd_set;
         timeout     <= to_set;
      end
   end

   // Pixel mux: only the busy client reaches the VGA port, with no added latency.
   always_comb begin
      vga_x      = 8'd0;
      vga_y      = 7'd0;
      vga_colour = 3'd0;
      vga_we     = 1'b0;
      if (state == BUSY) begin
         for (int i = 0; i < N_CLIENTS; i++) begin
            if (grant == GW'(i)) begin
               vga_x      = pix_x[8*i +: 8];
               vga_y      = pix_y[7*i +: 7];
               vga_colour = pix_colour[3*i +: 3];
               vga_we     = pix_we[i];
            end else begin
               vga_x      = vga_x;
               vga_y      = vga_y;
               vga_colour = vga_colour;
               vga_we     = vga_we;
            end
         end
      end else begin
         vga_we = 1'b0;
      end
   end

endmodule

// File: tb/tb_draw_scheduler.sv
// Bench for draw_scheduler: random traffic checked every cycle against a
// timeline model (pass start, go times, slot ends) derived from the pacing rules.
module tb_draw_scheduler;

   localparam int N   = 4;
   localparam int FT  = 100;
   localparam int MB  = 120;
   localparam int PXW = 8 * N;
   localparam int PYW = 7 * N;
   localparam int PCW = 3 * N;

   logic           clock = 1'b0;
   logic           reset;
   logic           enable;
   logic [N-1:0]   req;
   logic [N-1:0]   done;
   logic [PXW-1:0] pix_x;
   logic [PYW-1:0] pix_y;
   logic [PCW-1:0] pix_colour;
   logic [N-1:0]   pix_we;
   logic [N-1:0]   go;
   logic [7:0]     vga_x;
   logic [6:0]     vga_y;
   logic [2:0]     vga_colour;
   logic           vga_we;
   logic           frame_start;
   logic           pass_done;
   logic           timeout;
   logic           overrun;

   int checks = 0;
   int errors = 0;

   // model state (absolute cycle times since last reset release)
   int       cyc, fcnt, phase;
   bit       pend, ovr_exp, in_pass, to_flag;
   int       fs_at, pd_at, scan_at, go_at, end_at, cli;
   logic [N-1:0] rem;
   int       done_at [N];
   int       first_fs, n_ovr, n_to, n_pd, n_fs;

   always #5 clock = ~clock;

   draw_scheduler #(.N_CLIENTS(N), .FRAME_TICKS(FT), .MAX_BUSY(MB)) dut (
      .clock(clock), .reset(reset), .enable(enable), .req(req), .done(done),
      .pix_x(pix_x), .pix_y(pix_y), .pix_colour(pix_colour), .pix_we(pix_we),
      .go(go), .vga_x(vga_x), .vga_y(vga_y), .vga_colour(vga_colour),
      .vga_we(vga_we), .frame_start(frame_start), .pass_done(pass_done),
      .timeout(timeout), .overrun(overrun)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic bit busy_at(input int c);
      return (go_at >= 0) && (c > go_at) && (c < end_at);
   endfunction

   task automatic model_reset();
      cyc = 0; fcnt = 0; pend = 1'b0; ovr_exp = 1'b0; in_pass = 1'b0; to_flag = 1'b0;
      fs_at = -1; pd_at = -1; scan_at = -1; go_at = -1; end_at = -1; cli = 0; rem = '0;
      for (int j = 0; j < N; j++) done_at[j] = -1;
   endtask

   function automatic int pick_d(input int i);
      int r;
      case (phase)
         1: return 100;
         2: return (i == 0) ? MB + 30 : 40;
         3: return 5;
         default: begin
            r = $urandom_range(0, 7);
            if (r == 0) return MB + 1 + $urandom_range(0, 19);
            else if (r == 1) return MB;
            else if (r == 2) return 60 + $urandom_range(0, 59);
            else return 1 + $urandom_range(0, 7);
         end
      endcase
   endfunction

   task automatic chk_zero();
      chk("rst_go", 32'(go), 32'd0);
      chk("rst_vga_x", 32'(vga_x), 32'd0);
      chk("rst_vga_y", 32'(vga_y), 32'd0);
      chk("rst_vga_colour", 32'(vga_colour), 32'd0);
      chk("rst_vga_we", 32'(vga_we), 32'd0);
      chk("rst_frame_start", 32'(frame_start), 32'd0);
      chk("rst_pass_done", 32'(pass_done), 32'd0);
      chk("rst_timeout", 32'(timeout), 32'd0);
      chk("rst_overrun", 32'(overrun), 32'd0);
   endtask

   // compare outputs of cycle cyc against the model (pix_* still hold this cycle's values)
   task automatic compare_cycle();
      logic [N-1:0] go_e;
      go_e = '0;
      if (cyc == go_at) go_e[cli] = 1'b1;
      chk("go", 32'(go), 32'(go_e));
      chk("frame_start", 32'(frame_start), 32'(cyc == fs_at));
      chk("pass_done", 32'(pass_done), 32'(cyc == pd_at));
      chk("timeout", 32'(timeout), 32'(cyc == end_at && to_flag));
      chk("overrun", 32'(overrun), 32'(ovr_exp));
      if (busy_at(cyc)) begin
         chk("vga_x", 32'(vga_x), 32'(pix_x[8*cli +: 8]));
         chk("vga_y", 32'(vga_y), 32'(pix_y[7*cli +: 7]));
         chk("vga_colour", 32'(vga_colour), 32'(pix_colour[3*cli +: 3]));
         chk("vga_we", 32'(vga_we), 32'(pix_we[cli]));
      end else begin
         chk("vga_idle", 32'({vga_x, vga_y, vga_colour, vga_we}), 32'd0);
      end
      if (frame_start === 1'b1) begin
         n_fs++;
         if (first_fs < 0) first_fs = cyc;
      end
      if (overrun === 1'b1) n_ovr++;
      if (timeout === 1'b1) n_to++;
      if (pass_done === 1'b1) n_pd++;
   endtask

   task automatic drive_inputs();
      logic [N-1:0] d_v;
      case (phase)
         0: begin
            enable = ($urandom_range(0, 19) != 0);
            req    = ($urandom_range(0, 5) == 0) ? '0 : N'($urandom);
         end
         1: begin enable = 1'b1; req = '1; end
         2: begin enable = 1'b1; req = N'(3); end
         default: begin enable = 1'b1; req = '0; end
      endcase
      pix_x      = PXW'($urandom);
      pix_y      = PYW'($urandom);
      pix_colour = PCW'($urandom);
      pix_we     = N'($urandom);
      d_v = '0;
      for (int j = 0; j < N; j++) begin
         if (cyc == done_at[j]) d_v[j] = 1'b1;
         else if (phase == 0 && !(busy_at(cyc) && j == cli) && $urandom_range(0, 9) == 0) d_v[j] = 1'b1;
      end
      done = d_v;
   endtask

   // advance the timeline by one cycle using this cycle's inputs
   task automatic model_step();
      bit tick_c, consume;
      int d;
      tick_c  = enable && (fcnt == FT - 1);
      consume = !in_pass && pend;
      if (consume) begin
         in_pass = 1'b1; fs_at = cyc + 1; scan_at = cyc + 1; rem = req;
      end else if (cyc == scan_at) begin
         if (rem == '0) begin
            pd_at = cyc + 1; in_pass = 1'b0; scan_at = -1;
         end else begin
            cli = 0;
            while (!rem[cli]) cli++;
            rem[cli] = 1'b0;
            go_at = cyc + 1;
            d = pick_d(cli);
            done_at[cli] = go_at + d;
            to_flag = (d > MB);
            end_at  = to_flag ? go_at + MB + 1 : go_at + d + 1;
            scan_at = end_at;
         end
      end
      ovr_exp = tick_c && pend && !consume;
      pend    = (pend && !consume) || tick_c;
      if (enable) fcnt = tick_c ? 0 : fcnt + 1;
      cyc++;
   endtask

   task automatic cycle();
      @(negedge clock);
      compare_cycle();
      drive_inputs();
      model_step();
   endtask

   task automatic start_after_reset();
      @(negedge clock);
      chk_zero();
      reset = 1'b0;
      model_reset();
      drive_inputs();
      model_step();
   endtask

   task automatic reset_in_busy();
      int g = 0;
      while (!busy_at(cyc) && g < 3000) begin cycle(); g++; end
      chk("reach_busy", 32'(g < 3000), 32'd1);
      @(negedge clock);
      compare_cycle();
      pix_we = '1;
      #1;
      chk("vga_we_before_reset", 32'(vga_we), 32'd1);
      reset = 1'b1;
      #1;
      chk("vga_we_async_reset", 32'(vga_we), 32'd0);
      chk("go_async_reset_busy", 32'(go), 32'd0);
      repeat (3) begin @(negedge clock); chk_zero(); end
      start_after_reset();
   endtask

   task automatic reset_in_go();
      int g = 0;
      while (cyc != go_at && g < 3000) begin cycle(); g++; end
      chk("reach_go", 32'(g < 3000), 32'd1);
      @(negedge clock);
      compare_cycle();
      reset = 1'b1;
      #1;
      chk("go_async_reset", 32'(go), 32'd0);
      chk("vga_we_async_reset_go", 32'(vga_we), 32'd0);
      repeat (2) begin @(negedge clock); chk_zero(); end
      start_after_reset();
   endtask

   initial begin
      reset = 1'b1; enable = 1'b0; req = '0; done = '0;
      pix_x = '0; pix_y = '0; pix_colour = '0; pix_we = '0;
      phase = 3; first_fs = -1; n_ovr = 0; n_to = 0; n_pd = 0; n_fs = 0;
      model_reset();
      repeat (3) begin @(negedge clock); chk_zero(); end
      start_after_reset();

      // empty passes with enable held high: first frame_start lands at cycle 101
      repeat (150) cycle();
      chk("first_frame_start", 32'(first_fs), 32'd101);
      chk("empty_pass_done_seen", 32'(n_pd > 0), 32'd1);

      phase = 0; repeat (3000) cycle();
      phase = 1; repeat (1000) cycle();
      phase = 2; repeat (600) cycle();

      phase = 0;
      reset_in_busy();
      repeat (400) cycle();
      reset_in_go();
      repeat (2000) cycle();

      chk("saw_overrun", 32'(n_ovr > 0), 32'd1);
      chk("saw_timeout", 32'(n_to > 0), 32'd1);
      chk("saw_frames", 32'(n_fs > 10), 32'd1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
